// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: N-port round-robin arbiter onto one memory port,
// with an in-order read ID FIFO that steers responses to the issuing port.
module rv_mem_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_W  = $clog2(NUM_PORTS),
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
    localparam int MASK_W = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_op,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS*MASK_W-1:0]     req_mask,
    output logic                            mem_req_valid,
    output logic                            mem_req_op,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [DATA_WIDTH-1:0]           mem_req_data,
    output logic [MASK_W-1:0]               mem_req_mask,
    input  logic                            mem_req_ready,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_resp_data,
    output logic                            mem_resp_ready,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    input  logic [NUM_PORTS-1:0]            resp_ready,
    output logic [CNT_W-1:0]                outstanding,
    output logic                            err_unexp
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic OP_READ = 1'b1;

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic                 load;
    logic                 has_resp;
    logic                 pop;
    logic                 push;
    logic                 fifo_free;
    logic                 grant;
    logic [IDX_W-1:0]     gidx;
    logic [IDX_W-1:0]     head;
    logic [NUM_PORTS-1:0] eligible;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign outstanding = cnt;
    assign resp_data   = mem_resp_data;
    assign load        = !mem_req_valid || mem_req_ready;
    assign has_resp    = (cnt != '0);
    assign head        = id_fifo[rd_ptr];
    assign pop         = has_resp && mem_resp_valid && resp_ready[head];
    // A same-cycle pop frees the slot a new read is about to take.
    assign fifo_free   = (cnt < CNT_W'(MAX_OUTSTANDING)) || pop;
    assign push        = grant && (req_op[gidx] == OP_READ);

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] && (req_op[i] != OP_READ || fifo_free);
        end
    end

    // Walk down from the farthest slot so the nearest one after last wins.
    always_comb begin
        int p;
        p     = 0;
        grant = 1'b0;
        gidx  = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            p = (int'(last) + k) % NUM_PORTS;
            if (eligible[IDX_W'(p)]) begin
                grant = 1'b1;
                gidx  = IDX_W'(p);
            end
        end
        grant = grant && load && rst;
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gidx] = 1'b1;
        end
    end

    always_comb begin
        resp_valid     = '0;
        mem_resp_ready = 1'b0;
        if (rst) begin
            if (has_resp) begin
                resp_valid[head] = mem_resp_valid;
                mem_resp_ready   = resp_ready[head];
            end else begin
                mem_resp_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= gidx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid <= 1'b0;
            mem_req_op    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_mask  <= '0;
            last          <= IDX_W'(NUM_PORTS - 1);
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            err_unexp     <= 1'b0;
        end else begin
            if (load) begin
                if (grant) begin
                    mem_req_valid <= 1'b1;
                    mem_req_op    <= req_op[gidx];
                    mem_req_addr  <= req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_req_data  <= req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
                    mem_req_mask  <= req_mask[gidx*MASK_W +: MASK_W];
                    last          <= gidx;
                end else begin
                    mem_req_valid <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            if (mem_resp_valid && !has_resp) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule
